avalon_displays7seg_regs: RTL and testbench
===========================================

# avalon_displays7seg_regs

Avalon-MM slave register file that sits directly upstream of the per-digit hex-to-7-segment decoders in the displays7seg component. It holds the hexadecimal value for every digit, a per-digit enable mask, a per-digit blink mask and a global control register. It drives one 4-bit nibble plus one "lit" flag per digit, and contains a free-running blink prescaler. Each decoder instance takes its nibble; the lit flag blanks the digit at the component top level.

## Interface
Parameters:
- NDIGITS, 6, number of digits driven; legal range 1..8.
- BLINK_DIV, 25000000, clock cycles per blink half-period; legal range ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  word address: 0 DATA, 1 ENABLE, 2 BLINK, 3 CTRL.
- write  in  1  write strobe, one-cycle transfer, no waitrequest.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- read  in  1  read strobe.
- readdata  out  32  read data, fixed read latency 1.
- hex_value  out  4*NDIGITS  nibble i at bits [4i+3:4i]; goes to decoder i.
- digit_on  out  NDIGITS  1 = digit i lit, 0 = blank.

## Operation
Registers. Bits above the widths listed here are ignored on write and read as 0.
- DATA (addr 0): 4*NDIGITS bits; reset 0.
- ENABLE (addr 1): NDIGITS bits; reset all ones.
- BLINK (addr 2): NDIGITS bits; reset 0.
- CTRL (addr 3): bit0 global enable, reset 1; bit1 blink run, reset 0.

Writes:
- On a clk edge with write=1, each byte lane k with byteenable[k]=1 updates bits [8k+7:8k] of the addressed register.
- Lanes with byteenable[k]=0 are unchanged.

Reads:
- On a clk edge with read=1, readdata is loaded with the zero-extended addressed register.
- Otherwise readdata holds its value.
- readdata resets to 0.
- If read and write hit the same cycle, the write updates the register and readdata returns the pre-write value.

Blink prescaler:
- Counter cnt (ceil(log2(BLINK_DIV)) bits) and a phase bit.
- While CTRL.bit1=1: cnt increments each cycle. At cnt=BLINK_DIV-1, cnt wraps to 0 on the next edge and phase toggles on that same edge.
- While CTRL.bit1=0: cnt and phase are forced to 0 every cycle.
- A write that sets bit1 from 0 to 1 starts counting from cnt=0, phase=0.

Outputs (combinational from registers, no extra stage):
- hex_value = DATA.
- digit_on[i] = CTRL.bit0 & ENABLE[i] & ~(BLINK[i] & CTRL.bit1 & phase).

## Timing
- Register write: the new value appears on hex_value/digit_on immediately after the accepting edge, 0 cycles of added latency.
- Read: readdata is valid in the cycle after the read strobe (readLatency=1); back-to-back reads are supported every cycle.
- Blink: phase holds each value for exactly BLINK_DIV cycles, so the full period is 2*BLINK_DIV cycles. The first phase=1 edge comes BLINK_DIV edges after bit1 is set.
- Reset assertion at any time, including mid-count or mid-read, immediately forces:
  - all registers to their reset values;
  - cnt=0, phase=0, readdata=0;
  - the outputs to hex_value=0 and digit_on=all ones.
- No state advances until the first edge after reset deasserts.

## Test plan
Bench settings: NDIGITS=6, BLINK_DIV=4.
- Reset: assert reset mid-simulation -> hex_value=0x000000, digit_on=6'b111111, readdata=0 with no clock edge; read addr 3 after release -> 0x1.
- DATA write/readback:
  - write addr 0 = 0x00ABCDEF with byteenable=4'hF -> hex_value=0xABCDEF; read addr 0 -> 0x00ABCDEF one cycle after the strobe.
  - then write 0x11223344 with byteenable=4'b0010 -> hex_value=0xAB33EF.
- Masking:
  - write ENABLE=0x05 -> digit_on=6'b000101.
  - write CTRL=0 -> digit_on=0.
  - write ENABLE=0xFF, read back -> 0x3F.
- Blink: BLINK=0x01, ENABLE=0x3F, CTRL=0x3 -> digit_on[0] is 1 for 4 cycles, then 0 for 4, repeating; digits 1..5 stay 1. Clearing bit1 -> digit_on[0]=1 on the next cycle.
- Simultaneous read+write on addr 2 (old 0x01, new 0x02) -> readdata=0x01, register=0x02; then a read-every-cycle sweep of addresses 0..3 returns the correct values with latency 1.

Source files
------------

// File: rtl/avalon_displays7seg_regs_if.sv
// rtl/avalon_displays7seg_regs_if.sv - Avalon-MM slave bus bundle for the 7-segment register file
interface avalon_displays7seg_regs_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        read;
  logic [31:0] readdata;

  modport master (
    output address,
    output write,
    output writedata,
    output byteenable,
    output read,
    input  readdata
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    input  byteenable,
    input  read,
    output readdata
  );
endinterface

// File: rtl/avalon_displays7seg_regs.sv
// rtl/avalon_displays7seg_regs.sv - digit value/enable/blink registers and blink prescaler for displays7seg
module avalon_displays7seg_regs #(
  parameter int NDIGITS   = 6,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                     clk,
  input  logic                     reset,
  avalon_displays7seg_regs_if.slave bus,
  output logic [4*NDIGITS-1:0]     hex_value,
  output logic [NDIGITS-1:0]       digit_on
);

  localparam int DW    = 4 * NDIGITS;
  localparam int CNT_W = $clog2(BLINK_DIV);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_ENABLE = 2'd1;
  localparam logic [1:0] ADDR_BLINK  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  logic [DW-1:0]      data_q;
  logic [NDIGITS-1:0] enable_q;
  logic [NDIGITS-1:0] blink_q;
  logic [1:0]         ctrl_q;      // [0] global enable, [1] blink run
  logic [CNT_W-1:0]   cnt_q;
  logic               phase_q;
  logic [31:0]        readdata_q;

  logic [31:0] lane_mask;
  logic [31:0] sel_old;
  logic [31:0] merged;
  logic        unused_merged;

  // Zero-extended view of the addressed register and its byte-lane merge with writedata.
  always_comb begin
    lane_mask = {{8{bus.byteenable[3]}}, {8{bus.byteenable[2]}},
                 {8{bus.byteenable[1]}}, {8{bus.byteenable[0]}}};
    sel_old = 32'd0;
    case (bus.address)
      ADDR_DATA:   sel_old = 32'(data_q);
      ADDR_ENABLE: sel_old = 32'(enable_q);
      ADDR_BLINK:  sel_old = 32'(blink_q);
      default:     sel_old = 32'(ctrl_q);
    endcase
    merged = (sel_old & ~lane_mask) | (bus.writedata & lane_mask);
  end

  // Bits above each register's width are simply dropped on write.
  assign unused_merged = ^merged;

  // Register writes; the read path captures the pre-write value on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= '0;
      enable_q   <= '1;
      blink_q    <= '0;
      ctrl_q     <= 2'b01;
      readdata_q <= 32'd0;
    end else begin
      if (bus.read) begin
        readdata_q <= sel_old;
      end
      if (bus.write) begin
        case (bus.address)
          ADDR_DATA:   data_q   <= merged[DW-1:0];
          ADDR_ENABLE: enable_q <= merged[NDIGITS-1:0];
          ADDR_BLINK:  blink_q  <= merged[NDIGITS-1:0];
          default:     ctrl_q   <= merged[1:0];
        endcase
      end
    end
  end

  // Blink prescaler: held at zero while stopped, so a fresh start always begins at cnt=0, phase=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (!ctrl_q[1]) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign bus.readdata = readdata_q;
  assign hex_value    = data_q;
  assign digit_on     = {NDIGITS{ctrl_q[0]}} & enable_q &
                        ~(blink_q & {NDIGITS{ctrl_q[1] & phase_q}});

endmodule

// File: tb/tb_avalon_displays7seg_regs.sv
// tb/tb_avalon_displays7seg_regs.sv - scoreboard bench for the 7-segment register file
module tb_avalon_displays7seg_regs;
  localparam int ND = 6;
  localparam int BD = 4;
  localparam int DW = 4 * ND;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  avalon_displays7seg_regs_if bus ();
  logic [DW-1:0] hex_value;
  logic [ND-1:0] digit_on;

  avalon_displays7seg_regs #(.NDIGITS(ND), .BLINK_DIV(BD)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .hex_value (hex_value),
    .digit_on  (digit_on)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registers as plain words, blink phase derived from elapsed running edges.
  logic [31:0] m_reg [4];
  int          run_edges;
  logic [31:0] rd_q [$];
  logic [31:0] last_rd;

  function automatic logic [31:0] width_mask(input logic [1:0] a);
    case (a)
      2'd0:    return 32'h00FF_FFFF;
      2'd1:    return 32'h0000_003F;
      2'd2:    return 32'h0000_003F;
      default: return 32'h0000_0003;
    endcase
  endfunction

  function automatic logic [ND-1:0] exp_digit_on();
    logic [ND-1:0] r;
    bit phase;
    phase = ((run_edges / BD) % 2) == 1;
    for (int i = 0; i < ND; i++)
      r[i] = m_reg[3][0] & m_reg[1][i] & ~(m_reg[2][i] & m_reg[3][1] & phase);
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_reg[0] = 32'h0;
      m_reg[1] = 32'h3F;
      m_reg[2] = 32'h0;
      m_reg[3] = 32'h1;
      run_edges = 0;
      rd_q.delete();
      last_rd = 32'h0;
    end else begin
      logic [31:0] old, lm;
      logic        run_before;
      run_before = m_reg[3][1];
      old = m_reg[bus.address];
      if (bus.read) rd_q.push_back(old);
      if (bus.write) begin
        for (int k = 0; k < 4; k++) lm[8*k +: 8] = {8{bus.byteenable[k]}};
        m_reg[bus.address] = ((old & ~lm) | (bus.writedata & lm)) & width_mask(bus.address);
      end
      if (run_before) run_edges++;
      else run_edges = 0;
    end
  end

  // Monitor: readdata answers one cycle after each strobe, outputs always track the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_q.size() > 0) last_rd = rd_q.pop_front();
      check("readdata", bus.readdata, last_rd);
      check("hex_value", 32'(hex_value), m_reg[0] & 32'h00FF_FFFF);
      check("digit_on", 32'(digit_on), 32'(exp_digit_on()));
    end
  end

  task automatic cyc(input bit rd, input bit wr, input logic [1:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
    @(negedge clk);
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.writedata  = wd;
    bus.byteenable = be;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd, input logic [3:0] be);
    cyc(1'b0, 1'b1, a, wd, be);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  initial begin
    bus.read = 1'b0; bus.write = 1'b0; bus.address = 2'd0;
    bus.writedata = 32'h0; bus.byteenable = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    rd(2'd3); idle();
    check("reset_ctrl", bus.readdata, 32'h1);
    check("reset_digit_on", 32'(digit_on), 32'h3F);

    wr(2'd0, 32'h00AB_CDEF, 4'hF); idle();
    check("data_full", 32'(hex_value), 32'h00AB_CDEF);
    rd(2'd0); idle();
    check("data_readback", bus.readdata, 32'h00AB_CDEF);
    wr(2'd0, 32'h1122_3344, 4'b0010); idle();
    check("data_lane1", 32'(hex_value), 32'h00AB_33EF);

    // Asynchronous reset in the middle of a read, checked with no clock edge.
    rd(2'd0);
    @(posedge clk);
    #2;
    bus.read = 1'b0;
    reset = 1'b1;
    #1;
    check("async_rst_hex", 32'(hex_value), 32'h0);
    check("async_rst_digit_on", 32'(digit_on), 32'h3F);
    check("async_rst_readdata", bus.readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(2'd3); idle();
    check("post_rst_ctrl", bus.readdata, 32'h1);

    wr(2'd1, 32'h05, 4'hF); idle();
    check("enable_mask", 32'(digit_on), 32'h05);
    wr(2'd3, 32'h0, 4'hF); idle();
    check("global_off", 32'(digit_on), 32'h0);
    wr(2'd1, 32'hFF, 4'hF); rd(2'd1); idle();
    check("enable_width", bus.readdata, 32'h3F);
    wr(2'd3, 32'h1, 4'hF); idle();

    wr(2'd2, 32'h01, 4'hF);
    wr(2'd1, 32'h3F, 4'hF);
    wr(2'd3, 32'h03, 4'hF);
    for (int k = 0; k < 16; k++) begin
      idle();
      check("blink_d0", 32'(digit_on[0]), (((k / BD) % 2) == 0) ? 32'h1 : 32'h0);
      check("blink_others", 32'(digit_on[5:1]), 32'h1F);
    end
    for (int k = 0; k < 5; k++) idle();
    wr(2'd3, 32'h01, 4'hF); idle();
    check("blink_stop", 32'(digit_on[0]), 32'h1);

    cyc(1'b1, 1'b1, 2'd2, 32'h02, 4'hF); idle();
    check("rw_same_old", bus.readdata, 32'h01);
    rd(2'd2); idle();
    check("rw_same_new", bus.readdata, 32'h02);

    for (int a = 0; a < 4; a++) rd(2'(a));
    idle(); idle();

    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
          2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
    end
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
